hazard_stall_unit: RTL and testbench

- Hazard and stall controller for the 5-stage RISC-V pipeline.
- Drives the `NoOp` input of the main control decoder, plus PC/IF-ID write enables, the IF/ID flush and a whole-pipeline freeze.
- Detects load-use hazards against the instruction in ID and sequences multi-cycle data-memory loads with a small wait-state FSM.
- Sits beside the ID stage; its inputs come from the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_stall_unit_if.sv | 25 ++
 rtl/hazard_stall_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall controller bus: pipeline-register taps in, pipeline control out.
// master = pipeline side, slave = hazard_stall_unit.
interface hazard_stall_unit_if;
  logic [31:0] Inst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_Rd_i;
  logic        EXMEM_MemRead_i;
  logic        BranchTaken_i;
  logic        NoOp_o;
  logic        PCWrite_o;
  logic        IFIDWrite_o;
  logic        Flush_o;
  logic        Freeze_o;
  logic [15:0] StallCnt_o;

  modport master (
    output Inst_i, IDEX_MemRead_i, IDEX_Rd_i, EXMEM_MemRead_i, BranchTaken_i,
    input  NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o, StallCnt_o
  );

  modport slave (
    input  Inst_i, IDEX_MemRead_i, IDEX_Rd_i, EXMEM_MemRead_i, BranchTaken_i,
    output NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o, StallCnt_o
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection, branch flush and multi-cycle load freeze for the 5-stage pipeline.
// Optional stall performance counter built when HAZARD_PERF_EN is defined.
//
// state  | meaning
// S_IDLE | pipeline running; a load in MEM with MEM_LAT!=0 freezes this cycle
// S_WAIT | remaining freeze cycles counted down in r_cnt
// S_DONE | one unfrozen cycle so the finished load leaves MEM
module hazard_stall_unit #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
  localparam bit         LAT_EN   = (MEM_LAT != 0);
  localparam bit         LAT_ONE  = (MEM_LAT == 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_freeze_fsm;
  logic       w_use_rs1, w_use_rs2;
  logic [4:0] w_rs1, w_rs2;
  logic       w_hazard;
  logic       w_noop, w_pcwrite, w_ifidwrite, w_flush, w_freeze;
  logic       w_unused_bits;

  assign w_rs1 = bus.Inst_i[19:15];
  assign w_rs2 = bus.Inst_i[24:20];
  assign w_unused_bits = ^{bus.Inst_i[31:25], bus.Inst_i[14:7]};

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    if (bus.Inst_i[6:0] != 7'd0) begin
      case (bus.Inst_i[6:4])
        3'b011, 3'b010, 3'b110: begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
        end
        3'b001, 3'b000: w_use_rs1 = 1'b1;
        default: ;
      endcase
    end
  end

  // x0 is hardwired zero, so a load targeting it never produces a value to wait for
  assign w_hazard = bus.IDEX_MemRead_i && (bus.IDEX_Rd_i != 5'd0) &&
                    ((w_use_rs1 && (w_rs1 == bus.IDEX_Rd_i)) ||
                     (w_use_rs2 && (w_rs2 == bus.IDEX_Rd_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_freeze_fsm = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.EXMEM_MemRead_i && LAT_EN) begin
          w_freeze_fsm = 1'b1;
          if (LAT_ONE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        w_freeze_fsm = 1'b1;
        w_cnt_nxt    = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_DONE;
      end
      // the same load is still in MEM here, so it must not re-trigger
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_noop      = 1'b0;
    w_pcwrite   = 1'b1;
    w_ifidwrite = 1'b1;
    w_flush     = 1'b0;
    w_freeze    = 1'b0;
    if (!rst_i) begin
      w_noop      = 1'b1;
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (w_freeze_fsm) begin
      w_freeze    = 1'b1;
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (w_hazard) begin
      w_noop      = 1'b1;
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (bus.BranchTaken_i) begin
      w_flush     = 1'b1;
    end
  end

  assign bus.NoOp_o      = w_noop;
  assign bus.PCWrite_o   = w_pcwrite;
  assign bus.IFIDWrite_o = w_ifidwrite;
  assign bus.Flush_o     = w_flush;
  assign bus.Freeze_o    = w_freeze;

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 16'd0;
    end else if ((w_noop || w_freeze) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.StallCnt_o = r_stall_cnt;
`else
  assign bus.StallCnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: instances with MEM_LAT 0, 3 and 4.
// Stall-counter expectations follow HAZARD_PERF_EN as defined for the build.
module tb_hazard_stall_unit;

  localparam logic [31:0] I_ADD  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_ADDI = 32'h00518313; // addi x6,x3,5
  localparam logic [31:0] I_SW   = 32'h0051A023; // sw   x5,0(x3)

  logic clk_sys = 1'b0;
  logic rst_b   = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;

  always #5 clk_sys = ~clk_sys;

  hazard_stall_unit_if b0();
  hazard_stall_unit_if b3();
  hazard_stall_unit_if b4();

  hazard_stall_unit #(.MEM_LAT(0)) u_l0 (.clk_i(clk_sys), .rst_i(rst_b), .bus(b0));
  hazard_stall_unit #(.MEM_LAT(3)) u_l3 (.clk_i(clk_sys), .rst_i(rst_b), .bus(b3));
  hazard_stall_unit #(.MEM_LAT(4)) u_l4 (.clk_i(clk_sys), .rst_i(rst_b), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drv3(input logic mr, input logic [4:0] rd, input logic [31:0] inst,
                      input logic exm, input logic br);
    b3.IDEX_MemRead_i  = mr;
    b3.IDEX_Rd_i       = rd;
    b3.Inst_i          = inst;
    b3.EXMEM_MemRead_i = exm;
    b3.BranchTaken_i   = br;
  endtask

  logic [15:0] exp_perf5;
  logic        pat3 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        pat4 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
`ifdef HAZARD_PERF_EN
    exp_perf5 = 16'd5;
`else
    exp_perf5 = 16'd0;
`endif
    b0.Inst_i = 32'd0; b0.IDEX_MemRead_i = 1'b0; b0.IDEX_Rd_i = 5'd0;
    b0.EXMEM_MemRead_i = 1'b1; b0.BranchTaken_i = 1'b0;
    b4.Inst_i = 32'd0; b4.IDEX_MemRead_i = 1'b0; b4.IDEX_Rd_i = 5'd0;
    b4.EXMEM_MemRead_i = 1'b0; b4.BranchTaken_i = 1'b0;
    drv3(1'b1, 5'd5, I_ADD, 1'b1, 1'b1);

    // outputs forced while in reset, whatever the inputs
    #2;
    chk("rst_noop",  b3.NoOp_o, 1'b1);
    chk("rst_pcw",   b3.PCWrite_o, 1'b0);
    chk("rst_ifidw", b3.IFIDWrite_o, 1'b0);
    chk("rst_flush", b3.Flush_o, 1'b0);
    chk("rst_frz",   b3.Freeze_o, 1'b0);
    chk("rst_cnt",   b3.StallCnt_o, 16'd0);
    tick(); tick();
    drv3(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #2 rst_b = 1'b1;
    tick();
    chk("idle_pcw",  b3.PCWrite_o, 1'b1);
    chk("idle_noop", b3.NoOp_o, 1'b0);

    // load-use detection
    tick();
    drv3(1'b1, 5'd5, I_ADD, 1'b0, 1'b0);
    b0.IDEX_MemRead_i = 1'b1; b0.IDEX_Rd_i = 5'd5; b0.Inst_i = I_ADD;
    #1;
    chk("lu_add_noop",  b3.NoOp_o, 1'b1);
    chk("lu_add_pcw",   b3.PCWrite_o, 1'b0);
    chk("lu_add_ifidw", b3.IFIDWrite_o, 1'b0);
    chk("l0_lu_noop",   b0.NoOp_o, 1'b1);
    chk("l0_lu_frz",    b0.Freeze_o, 1'b0);
    tick();
    drv3(1'b1, 5'd0, I_ADD, 1'b0, 1'b0);
    b0.IDEX_MemRead_i = 1'b0;
    #1;
    chk("lu_x0_noop", b3.NoOp_o, 1'b0);
    chk("lu_x0_pcw",  b3.PCWrite_o, 1'b1);
    tick();
    drv3(1'b1, 5'd5, I_ADDI, 1'b0, 1'b0);
    #1 chk("lu_addi_noop", b3.NoOp_o, 1'b0);
    tick();
    drv3(1'b1, 5'd5, I_SW, 1'b0, 1'b0);
    #1 chk("lu_sw_noop", b3.NoOp_o, 1'b1);

    // single freeze of MEM_LAT=3, then stall count: 2 stalls + 3 frozen cycles
    tick();
    drv3(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk("frz1_frz", b3.Freeze_o, 1'b1);
      chk("frz1_pcw", b3.PCWrite_o, 1'b0);
      chk("l0_frz",   b0.Freeze_o, 1'b0);
    end
    tick();
    b3.EXMEM_MemRead_i = 1'b0;
    #1;
    chk("frz1_done", b3.Freeze_o, 1'b0);
    chk("perf5",     b3.StallCnt_o, exp_perf5);

    // branch alone, branch under load-use
    tick();
    drv3(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("br_flush", b3.Flush_o, 1'b1);
    chk("br_noop",  b3.NoOp_o, 1'b0);
    tick();
    drv3(1'b1, 5'd5, I_ADD, 1'b0, 1'b1);
    #1;
    chk("brlu_noop",  b3.NoOp_o, 1'b1);
    chk("brlu_flush", b3.Flush_o, 1'b0);

    // held load in MEM with a taken branch: freeze 3, DONE, freeze 3, DONE
    tick();
    drv3(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      #1;
      chk($sformatf("seq_frz[%0d]", i),   b3.Freeze_o, pat3[i]);
      chk($sformatf("seq_flush[%0d]", i), b3.Flush_o, !pat3[i]);
      chk($sformatf("l0_seq[%0d]", i),    b0.Freeze_o, 1'b0);
    end
    drv3(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // async reset in the 2nd frozen cycle of MEM_LAT=4
    tick();
    b4.EXMEM_MemRead_i = 1'b1;
    #1 chk("l4_frz1", b4.Freeze_o, 1'b1);
    tick();
    chk("l4_frz2", b4.Freeze_o, 1'b1);
    #1 rst_b = 1'b0;
    #1;
    chk("l4_rst_frz",  b4.Freeze_o, 1'b0);
    chk("l4_rst_noop", b4.NoOp_o, 1'b1);
    b4.EXMEM_MemRead_i = 1'b0;
    tick(); tick();
    #2 rst_b = 1'b1;
    tick();
    chk("l4_post_pcw",  b4.PCWrite_o, 1'b1);
    chk("l4_post_frz",  b4.Freeze_o, 1'b0);
    chk("l4_post_cnt",  b4.StallCnt_o, 16'd0);
    tick();
    b4.EXMEM_MemRead_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1 chk($sformatf("l4_seq[%0d]", i), b4.Freeze_o, pat4[i]);
    end
    b4.EXMEM_MemRead_i = 1'b0;

`ifdef HAZARD_PERF_EN
    // continuous load-use stall drives the counter into saturation
    tick();
    drv3(1'b1, 5'd5, I_ADD, 1'b0, 1'b0);
    repeat (65540) tick();
    chk("perf_sat", b3.StallCnt_o, 16'hFFFF);
    repeat (3) tick();
    chk("perf_sat_hold", b3.StallCnt_o, 16'hFFFF);
    drv3(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
`else
    chk("perf_off", b3.StallCnt_o, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
